// File: rtl/shift_add_mult_ctrl.sv
// ============================================================================
// Module  : shift_add_mult_ctrl
// Brief   : Sequencer for an N-bit shift-and-add multiplier datapath.
//           Optional early termination of adds: SHIFT_ADD_MULT_ZERO_SKIP_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_add_mult_ctrl #(
    parameter int N     = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             ack,
    input  logic             q_lsb,
    input  logic             q_zero,
    output logic             ready,
    output logic             busy,
    output logic             load,
    output logic             add_en,
    output logic             shift_en,
    output logic             valid,
    output logic [CNT_W-1:0] iter
);

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_LOAD  = 3'd1;
    localparam logic [2:0] c_S_ADD   = 3'd2;
    localparam logic [2:0] c_S_SHIFT = 3'd3;
    localparam logic [2:0] c_S_DONE  = 3'd4;

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] c_FULL = CNT_W'(N);

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [CNT_W-1:0] r_iter;
    logic             r_skip;
    logic             w_zero_hit;

`ifdef SHIFT_ADD_MULT_ZERO_SKIP_EN
    assign w_zero_hit = (r_state == c_S_ADD) && q_zero;
`else
    logic w_unused_q_zero;
    assign w_unused_q_zero = q_zero;
    assign w_zero_hit      = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = c_S_IDLE;
        end else begin
            case (r_state)
                c_S_IDLE:  if (start) w_next = c_S_LOAD;
                c_S_LOAD:  w_next = c_S_ADD;
                c_S_ADD:   w_next = c_S_SHIFT;
                c_S_SHIFT: begin
                    if (r_iter == c_LAST)
                        w_next = c_S_DONE;
                    else if (r_skip)
                        w_next = c_S_SHIFT;
                    else
                        w_next = c_S_ADD;
                end
                c_S_DONE:  if (ack) w_next = c_S_IDLE;
                default:   w_next = c_S_IDLE;
            endcase
        end
    end

    // The counter tracks shifts actually issued, so a SHIFT cycle that coincides
    // with abort still counts: shift_en was already presented to the datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_S_IDLE;
            r_iter  <= '0;
            r_skip  <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                c_S_LOAD: begin
                    r_iter <= '0;
                    r_skip <= 1'b0;
                end
                c_S_ADD: begin
                    if (w_zero_hit) r_skip <= 1'b1;
                end
                c_S_SHIFT: begin
                    if (r_iter != c_FULL) r_iter <= r_iter + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ready    = (r_state == c_S_IDLE);
    assign busy     = (r_state == c_S_LOAD) || (r_state == c_S_ADD) || (r_state == c_S_SHIFT);
    assign load     = (r_state == c_S_LOAD);
    assign shift_en = (r_state == c_S_SHIFT);
    assign valid    = (r_state == c_S_DONE);
    assign add_en   = (r_state == c_S_ADD) && q_lsb && !w_zero_hit;
    assign iter     = r_iter;

endmodule

`default_nettype wire

// File: tb/tb_shift_add_mult_ctrl.sv
// ============================================================================
// Module  : tb_shift_add_mult_ctrl
// Brief   : Self-checking bench for shift_add_mult_ctrl with a behavioural
//           multiplier datapath; honours SHIFT_ADD_MULT_ZERO_SKIP_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_add_mult_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       ack = 1'b0;
    logic       q_lsb;
    logic       q_zero;
    logic       ready, busy, load, add_en, shift_en, valid;
    logic [3:0] iter;

    int total = 0;
    int bad   = 0;

    logic [16:0] p;
    logic [7:0]  mrem;
    logic [7:0]  mcand  = 8'h00;
    logic [7:0]  mult_in = 8'h00;

    shift_add_mult_ctrl #(.N(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .ack(ack),
        .q_lsb(q_lsb), .q_zero(q_zero), .ready(ready), .busy(busy),
        .load(load), .add_en(add_en), .shift_en(shift_en), .valid(valid),
        .iter(iter)
    );

    always #5 clk = ~clk;

    // Behavioural datapath: product/multiplier shift register plus multiplicand.
    always @(posedge clk) begin
        if (load) begin
            p    <= {9'd0, mult_in};
            mrem <= mult_in;
        end else begin
            if (add_en) p[16:8] <= p[16:8] + {1'b0, mcand};
            if (shift_en) begin
                p    <= (add_en ? {p[16:8] + {1'b0, mcand}, p[7:0]} : p) >> 1;
                mrem <= mrem >> 1;
            end
        end
    end
    assign q_lsb  = p[0];
    assign q_zero = (mrem == 8'd0);

    function automatic int exp_lat(input logic [7:0] m);
`ifdef SHIFT_ADD_MULT_ZERO_SKIP_EN
        for (int k = 1; k <= 8; k++)
            if ((m >> (k - 1)) == 8'd0) return 1 + 2 * k + (8 - k);
`endif
        return 17;
    endfunction

    // Observes one operation starting #1 after the edge that sampled start.
    task automatic run_mon(output int edges, output int loads, output int shifts,
                           output logic [15:0] mask);
        edges = 0; loads = 0; shifts = 0; mask = '0;
        while (valid !== 1'b1 && edges < 60) begin
            if (load === 1'b1) loads++;
            if (add_en === 1'b1) mask |= 16'(1) << shifts;
            if (shift_en === 1'b1) shifts++;
            @(posedge clk); edges++; #1;
        end
    endtask

    task automatic launch(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        mult_in = a; mcand = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #2;
        total++;
        if (ready !== 1'b1 || busy !== 1'b0 || valid !== 1'b0 || load !== 1'b0 ||
            shift_en !== 1'b0 || add_en !== 1'b0 || iter !== 4'd0) begin
            bad++;
            $display("FAIL reset: ready=%b busy=%b valid=%b load=%b shift=%b add=%b iter=%0d, required 1 0 0 0 0 0 0",
                     ready, busy, valid, load, shift_en, add_en, iter);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int e, l, s; logic [15:0] m;
        launch(8'hA5, 8'h3C);
        run_mon(e, l, s, m);
        total++; if (e != 17) begin bad++; $display("FAIL basic_latency: got %0d edges, required 17", e); end
        total++; if (l != 1) begin bad++; $display("FAIL basic_loads: got %0d, required 1", l); end
        total++; if (s != 8) begin bad++; $display("FAIL basic_shifts: got %0d, required 8", s); end
        total++; if (m !== 16'h00A5) begin bad++; $display("FAIL basic_add_iters: got %h, required 00a5", m); end
        total++; if (iter !== 4'd8) begin bad++; $display("FAIL basic_iter: got %0d, required 8", iter); end
        total++; if (p[15:0] !== 16'h26AC) begin bad++; $display("FAIL basic_product: got %h, required 26ac", p[15:0]); end
    endtask

    task automatic test_hold_ack;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); start = ~start;
            @(posedge clk); #1;
            total++;
            if (valid !== 1'b1 || ready !== 1'b0 || load !== 1'b0) begin
                bad++;
                $display("FAIL hold_ack cycle %0d: valid=%b ready=%b load=%b, required 1 0 0", i, valid, ready, load);
            end
        end
        @(negedge clk); start = 1'b0; ack = 1'b1;
        @(posedge clk); #1; ack = 1'b0;
        total++;
        if (ready !== 1'b1 || valid !== 1'b0) begin
            bad++; $display("FAIL ack_release: ready=%b valid=%b, required 1 0", ready, valid);
        end
    endtask

    task automatic test_random;
        int e, l, s; logic [15:0] m; logic [7:0] a, b;
        for (int n = 0; n < 6; n++) begin
            a = 8'($urandom); b = 8'($urandom);
            if (n == 0) a = 8'h00;
            launch(a, b);
            run_mon(e, l, s, m);
            total++;
            if (e != exp_lat(a) || l != 1 || s != 8 || m !== {8'd0, a} ||
                iter !== 4'd8 || p[15:0] !== 16'(a * b)) begin
                bad++;
                $display("FAIL random %h*%h: edges=%0d/%0d loads=%0d shifts=%0d mask=%h iter=%0d prod=%h, required prod %h",
                         a, b, e, exp_lat(a), l, s, m, iter, p[15:0], 16'(a * b));
            end
            @(negedge clk); ack = 1'b1;
            @(posedge clk); #1; ack = 1'b0;
        end
    endtask

    task automatic test_abort;
        int shifts = 0; int guard = 0; int stray = 0;
        launch(8'hFF, 8'h11);
        while (!(shift_en === 1'b1 && shifts == 2) && guard < 40) begin
            if (shift_en === 1'b1) shifts++;
            @(posedge clk); #1; guard++;
        end
        abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        total++;
        if (ready !== 1'b1 || busy !== 1'b0 || iter !== 4'd3) begin
            bad++; $display("FAIL abort_state: ready=%b busy=%b iter=%0d, required 1 0 3", ready, busy, iter);
        end
        for (int i = 0; i < 20; i++) begin
            if (shift_en !== 1'b0 || valid !== 1'b0 || load !== 1'b0 || add_en !== 1'b0) stray++;
            @(posedge clk); #1;
        end
        total++;
        if (stray != 0 || iter !== 4'd3) begin
            bad++; $display("FAIL abort_quiet: stray cycles=%0d iter=%0d, required 0 and 3", stray, iter);
        end
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(posedge clk); #1; start = 1'b0; abort = 1'b0;
        total++;
        if (ready !== 1'b1 || load !== 1'b0) begin
            bad++; $display("FAIL abort_vs_start: ready=%b load=%b, required 1 0", ready, load);
        end
    endtask

    task automatic test_async_reset;
        int guard = 0; int e, l, s; logic [15:0] m;
        launch(8'hFF, 8'h5A);
        while (add_en !== 1'b1 && guard < 40) begin
            @(posedge clk); #1; guard++;
        end
        #1; rst = 1'b1; #1;
        total++;
        if (add_en !== 1'b0 || busy !== 1'b0 || valid !== 1'b0 || ready !== 1'b1 || iter !== 4'd0 || guard >= 40) begin
            bad++;
            $display("FAIL async_reset: add=%b busy=%b valid=%b ready=%b iter=%0d guard=%0d, required 0 0 0 1 0",
                     add_en, busy, valid, ready, iter, guard);
        end
        @(negedge clk); rst = 1'b0;
        launch(8'hA5, 8'h3C);
        run_mon(e, l, s, m);
        total++;
        if (e != 17 || l != 1 || s != 8 || p[15:0] !== 16'h26AC) begin
            bad++; $display("FAIL post_reset_op: edges=%0d loads=%0d shifts=%0d prod=%h, required 17 1 8 26ac", e, l, s, p[15:0]);
        end
        @(negedge clk); ack = 1'b1;
        @(posedge clk); #1; ack = 1'b0;
    endtask

    task automatic test_back_to_back;
        int e, l, s; logic [15:0] m; logic [7:0] a2, b2;
        launch(8'h5B, 8'h77);
        start = 1'b1;
        run_mon(e, l, s, m);
        total++;
        if (e != exp_lat(8'h5B) || s != 8 || p[15:0] !== 16'(8'h5B * 8'h77)) begin
            bad++; $display("FAIL b2b_first: edges=%0d shifts=%0d prod=%h, required %0d 8 %h", e, s, p[15:0], exp_lat(8'h5B), 16'(8'h5B * 8'h77));
        end
        a2 = 8'($urandom) | 8'h80; b2 = 8'($urandom);
        @(negedge clk); ack = 1'b1; mult_in = a2; mcand = b2;
        @(posedge clk); #1; ack = 1'b0;
        total++;
        if (ready !== 1'b1 || load !== 1'b0) begin
            bad++; $display("FAIL b2b_idle_gap: ready=%b load=%b, required 1 0", ready, load);
        end
        @(posedge clk); #1;
        total++;
        if (load !== 1'b1) begin
            bad++; $display("FAIL b2b_second_load: load=%b, required 1", load);
        end
        run_mon(e, l, s, m);
        start = 1'b0;
        total++;
        if (e != 17 || l != 1 || s != 8 || iter !== 4'd8 || p[15:0] !== 16'(a2 * b2)) begin
            bad++; $display("FAIL b2b_second: edges=%0d loads=%0d shifts=%0d iter=%0d prod=%h, required 17 1 8 8 %h", e, l, s, iter, p[15:0], 16'(a2 * b2));
        end
        @(negedge clk); ack = 1'b1;
        @(posedge clk); #1; ack = 1'b0;
    endtask

    task automatic test_zero_skip;
        int e, l, s; logic [15:0] m;
        launch(8'h03, 8'hC9);
        run_mon(e, l, s, m);
        total++;
        if (e != exp_lat(8'h03) || s != 8 || m !== 16'h0003 || p[15:0] !== 16'(8'h03 * 8'hC9)) begin
            bad++; $display("FAIL zero_skip: edges=%0d shifts=%0d mask=%h prod=%h, required %0d 8 0003 %h",
                            e, s, m, p[15:0], exp_lat(8'h03), 16'(8'h03 * 8'hC9));
        end
        @(negedge clk); ack = 1'b1;
        @(posedge clk); #1; ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold_ack();
        test_random();
        test_abort();
        test_async_reset();
        test_back_to_back();
        test_zero_skip();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
